// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage RV32I pipeline: load-use bubbles, branch squash, memory freeze/timeout.
// Optional performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_inst,
    input  logic             id_valid,
    input  logic [31:0]      ex_inst,
    input  logic             ex_valid,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_wait_next;
    logic        r_mem_err;
    logic        w_mem_err_next;
    logic        w_advance;

    logic [6:0]  w_id_op;
    logic [4:0]  w_ex_rd;
    logic        w_reads_rs1;
    logic        w_reads_rs2;
    logic        w_lu;
    logic        w_ms;
    logic        w_unused_bits;

    assign w_id_op     = id_inst[6:0];
    assign w_ex_rd     = ex_inst[11:7];
    assign w_reads_rs1 = (w_id_op != OP_LUI) && (w_id_op != OP_AUIPC) && (w_id_op != OP_JAL);
    assign w_reads_rs2 = (w_id_op == OP_REG) || (w_id_op == OP_STORE) || (w_id_op == OP_BRANCH);

    assign w_lu = ex_valid && id_valid && (ex_inst[6:0] == OP_LOAD) && (w_ex_rd != 5'd0) &&
                  ((w_reads_rs1 && (w_ex_rd == id_inst[19:15])) ||
                   (w_reads_rs2 && (w_ex_rd == id_inst[24:20])));

    assign w_ms = mem_req && !mem_ready;

    // Only opcode and register fields take part in hazard detection.
    assign w_unused_bits = ^{id_inst[31:25], id_inst[14:7], ex_inst[31:12]};

    always_comb begin
        pc_en          = 1'b0;
        ifid_en        = 1'b0;
        idex_en        = 1'b0;
        exmem_en       = 1'b0;
        memwb_en       = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        w_state_next   = r_state;
        w_wait_next    = r_wait_cnt;
        w_mem_err_next = r_mem_err;
        w_advance      = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_ms) begin
                    w_state_next = ST_MEM_WAIT;
                    w_wait_next  = 8'd1;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                if (!mem_ready) begin
                    w_wait_next = r_wait_cnt + 8'd1;
                    if (r_wait_cnt == WAIT_LAST) begin
                        w_state_next   = ST_HALT;
                        w_mem_err_next = 1'b1;
                    end
                end else begin
                    w_advance    = 1'b1;
                    w_state_next = ST_RUN;
                    w_wait_next  = 8'd0;
                end
            end
            ST_HALT: begin
                w_state_next = ST_HALT;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        // Branch squash outranks the load-use bubble: the dependent instruction is wrong-path anyway.
        if (w_advance) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (br_taken) begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (w_lu) begin
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
        end

        if (rst) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_next;
            r_mem_err  <= w_mem_err_next;
        end
    end

    assign halted  = (r_state == ST_HALT);
    assign mem_err = r_mem_err;

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (ifid_flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard/branch/memory/timeout steps, then random traffic vs a reference model.
module tb_pipe_hazard_ctrl;

    localparam int MT  = 4;
    localparam int CW  = 8;
    localparam int SAT = (1 << CW) - 1;
`ifdef PIPE_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] LW   = 32'h0000_A283; // lw x5,0(x1)
    localparam logic [31:0] ADD  = 32'h0022_8333; // add x6,x5,x2
    localparam logic [31:0] LUI  = 32'h0002_8337; // lui x6,0x28
    localparam logic [31:0] LW0  = 32'h0000_2003; // lw x0,0(x0)
    localparam logic [31:0] ADD0 = 32'h0000_0033; // add x0,x0,x0

    localparam logic [7:0] NOCHK  = 8'h00;
    localparam logic [7:0] W_FRZ  = 8'h80;
    localparam logic [7:0] W_RUN  = 8'hFC;
    localparam logic [7:0] W_LU   = 8'h9D;
    localparam logic [7:0] W_BR   = 8'hFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   id_inst, ex_inst;
    logic          id_valid, ex_valid, br_taken, mem_req, mem_ready;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic          halted, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    ctrl;

    assign ctrl = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_inst(id_inst), .id_valid(id_valid), .ex_inst(ex_inst), .ex_valid(ex_valid),
        .br_taken(br_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .halted(halted), .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: waiting flag plus number of frozen cycles seen in the current memory wait.
    bit m_waiting, m_halted, m_err;
    int m_frozen, m_stall, m_flush;

    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                             7'b1100111, 7'b0110111, 7'b0010111, 7'b0001111, 7'b1110011};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_lu(input logic [31:0] ii, input logic iv, input logic [31:0] ei, input logic ev);
        logic [4:0] rd;
        logic [6:0] op;
        bit r1, r2;
        if (!(iv && ev) || ei[6:0] != 7'b0000011) return 1'b0;
        rd = ei[11:7];
        if (rd == 5'd0) return 1'b0;
        op = ii[6:0];
        r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return (r1 && rd == ii[19:15]) || (r2 && rd == ii[24:20]);
    endfunction

    function automatic logic [6:0] model_ctrl(input logic [31:0] ii, input logic iv, input logic [31:0] ei,
                                              input logic ev, input logic br, input logic mr, input logic rdy);
        if (m_halted) return 7'b0000000;
        if (m_waiting ? !rdy : (mr && !rdy)) return 7'b0000000;
        if (br) return 7'b1111111;
        if (model_lu(ii, iv, ei, ev)) return 7'b0011101;
        return 7'b1111100;
    endfunction

    task automatic model_reset();
        m_waiting = 0; m_halted = 0; m_err = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
    endtask

    task automatic pulse_reset();
        id_inst = NOP; id_valid = 0; ex_inst = NOP; ex_valid = 0;
        br_taken = 0; mem_req = 0; mem_ready = 0;
        rst = 1'b1;
        #2;
        check("rst_ctrl", 32'(ctrl), 32'h03);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        rst = 1'b0;
        model_reset();
        $display("reset pulse: ctrl=%b halted=%0b mem_err=%0b", ctrl, halted, mem_err);
        @(posedge clk); #1;
    endtask

    task automatic step(input string tag, input logic [31:0] ii, input logic iv, input logic [31:0] ei,
                        input logic ev, input logic br, input logic mr, input logic rdy, input logic [7:0] want);
        logic [6:0] exp;
        id_inst = ii; id_valid = iv; ex_inst = ei; ex_valid = ev;
        br_taken = br; mem_req = mr; mem_ready = rdy;
        #2;
        exp = model_ctrl(ii, iv, ei, ev, br, mr, rdy);
        check({tag, "_ctrl"}, 32'(ctrl), 32'(exp));
        if (want[7]) check({tag, "_ctrl_spec"}, 32'(ctrl), 32'(want[6:0]));
        check({tag, "_halted"}, 32'(halted), 32'(m_halted));
        check({tag, "_mem_err"}, 32'(mem_err), 32'(m_err));
        check({tag, "_stall_cnt"}, 32'(stall_cnt), PERF ? m_stall : 0);
        check({tag, "_flush_cnt"}, 32'(flush_cnt), PERF ? m_flush : 0);
        $display("%s: br=%0b mr=%0b rdy=%0b lu=%0b ctrl=%b exp=%b halted=%0b stall=%0d flush=%0d",
                 tag, br, mr, rdy, model_lu(ii, iv, ei, ev), ctrl, exp, halted, stall_cnt, flush_cnt);
        if (!exp[6] && m_stall < SAT) m_stall++;
        if (exp[1] && m_flush < SAT) m_flush++;
        if (!m_halted) begin
            if (!m_waiting) begin
                if (mr && !rdy) begin
                    m_waiting = 1; m_frozen = 1;
                end
            end else if (!rdy) begin
                m_frozen++;
                if (m_frozen == MT) begin
                    m_halted = 1; m_err = 1;
                end
            end else begin
                m_waiting = 0; m_frozen = 0;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] ri, re;
        rst = 1'b1;
        #1;
        pulse_reset();

        // Load-use bubble, then the NOP it created sits in EX.
        step("lu", ADD, 1, LW, 1, 0, 0, 0, W_LU);
        step("lu_after", ADD, 1, NOP, 1, 0, 0, 0, W_RUN);
        check("lu_stall_cnt", 32'(stall_cnt), PERF ? 1 : 0);
        step("lui_guard", LUI, 1, LW, 1, 0, 0, 0, W_RUN);
        step("rd0_guard", ADD0, 1, LW0, 1, 0, 0, 0, W_RUN);
        step("lu_id_invalid", ADD, 0, LW, 1, 0, 0, 0, W_RUN);

        pulse_reset();
        step("branch", NOP, 1, NOP, 1, 1, 0, 0, W_BR);
        check("branch_flush_cnt", 32'(flush_cnt), PERF ? 1 : 0);
        step("branch_lu", ADD, 1, LW, 1, 1, 0, 0, W_BR);
        check("branch_lu_stall_cnt", 32'(stall_cnt), 32'd0);
        step("ready_no_req", NOP, 1, NOP, 1, 0, 0, 1, W_RUN);

        pulse_reset();
        for (int i = 0; i < 3; i++) step("memwait", ADD, 1, LW, 1, 1, 1, 0, W_FRZ);
        step("mem_release", NOP, 1, NOP, 1, 0, 1, 1, W_RUN);
        check("memwait_stall_cnt", 32'(stall_cnt), PERF ? 3 : 0);

        pulse_reset();
        for (int i = 0; i < MT; i++) step("timeout", NOP, 1, NOP, 1, 0, 1, 0, W_FRZ);
        step("halt", NOP, 1, NOP, 1, 1, 0, 1, W_FRZ);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_mem_err", 32'(mem_err), 32'd1);
        for (int i = 0; i < SAT; i++) step("halt_hold", NOP, 1, NOP, 1, 0, 0, 1, W_FRZ);
        check("stall_saturated", 32'(stall_cnt), PERF ? SAT : 0);
        pulse_reset();
        step("run_again", NOP, 1, NOP, 1, 0, 0, 0, W_RUN);

        for (int n = 0; n < 1500; n++) begin
            if (m_halted && $urandom_range(0, 15) == 0) begin
                pulse_reset();
            end else begin
                ri = {$urandom_range(0, 127) & 7'h7F, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      3'($urandom), 5'($urandom), ops[$urandom_range(0, 10)]};
                re = {20'($urandom), 5'($urandom_range(0, 3)),
                      ($urandom_range(0, 1) == 1) ? 7'b0000011 : ops[$urandom_range(0, 10)]};
                ri[31:25] = 7'($urandom);
                step("rand", ri, 1'($urandom_range(0, 7) != 0), re, 1'($urandom_range(0, 7) != 0),
                     1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) == 0),
                     1'($urandom_range(0, 1)), NOCHK);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
